// File: rtl/song_player_if.sv
// Control, song and display/score signals between the song player and its surroundings.
interface song_player_if;
  logic        load;
  logic [31:0] song_in;
  logic        start;
  logic [1:0]  hit;
  logic [1:0]  current_note;
  logic [31:0] window;
  logic [4:0]  position;
  logic        playing;
  logic        done;
  logic [4:0]  score;
  logic [4:0]  misses;

  modport master (
    output load, song_in, start, hit,
    input  current_note, window, position, playing, done, score, misses
  );

  modport slave (
    input  load, song_in, start, hit,
    output current_note, window, position, playing, done, score, misses
  );
endinterface

// File: rtl/song_player.sv
// Plays a packed 16-note song one note per beat and judges button presses against each note.
// Optional SONG_PLAYER_LOOP_EN: replay the song forever with saturating score/miss counts.
module song_player #(
  parameter int unsigned BEAT_CYCLES = 10
) (
  input logic         clk,
  input logic         rst,
  song_player_if.slave bus
);

  localparam int unsigned CntW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     song_q, song_d;
  logic [31:0]     window_q, window_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      acc_q, acc_d;
  logic [4:0]      pos_q, pos_d;
  logic [4:0]      score_q, score_d;
  logic [4:0]      miss_q, miss_d;
  logic [1:0]      h;
  logic            judge_hit, judge_miss;

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    window_d   = window_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    pos_d      = pos_q;
    score_d    = score_q;
    miss_d     = miss_q;
    h          = acc_q | bus.hit;
    judge_hit  = 1'b0;
    judge_miss = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.load) song_d = bus.song_in;
        if (bus.start) begin
          state_d  = StPlay;
          // A load in the same cycle bypasses song_q so the new song plays at once.
          window_d = bus.load ? bus.song_in : song_q;
          cnt_d    = '0;
          acc_d    = '0;
          pos_d    = '0;
          score_d  = '0;
          miss_d   = '0;
        end
      end
      StPlay: begin
        acc_d = h;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          acc_d = '0;
          cnt_d = '0;
          if (window_q[1:0] != 2'b00) begin
            judge_hit  = (h == window_q[1:0]);
            judge_miss = !judge_hit;
          end else begin
            judge_miss = (h != 2'b00);
          end
`ifdef SONG_PLAYER_LOOP_EN
          if (judge_hit && score_q != 5'd31) score_d = score_q + 5'd1;
          if (judge_miss && miss_q != 5'd31) miss_d = miss_q + 5'd1;
`else
          if (judge_hit) score_d = score_q + 5'd1;
          if (judge_miss) miss_d = miss_q + 5'd1;
`endif
          if (pos_q != 5'd15) begin
            window_d = window_q >> 2;
            pos_d    = pos_q + 5'd1;
          end else begin
`ifdef SONG_PLAYER_LOOP_EN
            window_d = song_q;
            pos_d    = '0;
`else
            state_d  = StDone;
            window_d = '0;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      song_q   <= '0;
      window_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      pos_q    <= '0;
      score_q  <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      pos_q    <= pos_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.current_note = window_q[1:0];
  assign bus.window       = window_q;
  assign bus.position     = pos_q;
  assign bus.playing      = (state_q == StPlay);
  assign bus.done         = (state_q == StDone);
  assign bus.score        = score_q;
  assign bus.misses       = miss_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: scoreboard of expected windows and final counts per playback.
module tb_song_player;

  localparam int unsigned B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  song_player_if bus ();

  song_player #(.BEAT_CYCLES(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_song = '0;
  logic [1:0]  plan[16];
  bit          last_only[16];
  int          ign_beat = -1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_note"}, 32'(bus.current_note), 32'd0);
    chk({tag, "_window"}, bus.window, 32'd0);
    chk({tag, "_position"}, 32'(bus.position), 32'd0);
    chk({tag, "_playing"}, 32'(bus.playing), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_score"}, 32'(bus.score), 32'd0);
    chk({tag, "_misses"}, 32'(bus.misses), 32'd0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      plan[i]      = 2'b00;
      last_only[i] = 1'b0;
    end
    ign_beat = -1;
  endtask

  // sep_load: load a cycle before start; otherwise load and start together.
  task automatic play(input logic [31:0] s, input bit do_load, input bit sep_load);
    int sc;
    int ms;
    logic [1:0]  n;
    logic [31:0] w;
    if (do_load) exp_song = s;
    if (do_load && sep_load) begin
      bus.load = 1'b1;
      bus.song_in = s;
      tick();
      bus.load = 1'b0;
    end
    sc = 0;
    ms = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(exp_song >> (2 * i));
      n = exp_song[2*i +: 2];
      if (n != 2'b00) begin
        if (plan[i] == n) sc++;
        else ms++;
      end else if (plan[i] != 2'b00) begin
        ms++;
      end
    end
    exp_q.push_back(32'(sc));
    exp_q.push_back(32'(ms));

    bus.start = 1'b1;
    if (do_load && !sep_load) begin
      bus.load = 1'b1;
      bus.song_in = s;
    end
    tick();
    bus.start = 1'b0;
    bus.load = 1'b0;
    chk("start_playing", 32'(bus.playing), 32'd1);
    chk("start_score_clr", 32'(bus.score), 32'd0);
    chk("start_misses_clr", 32'(bus.misses), 32'd0);

    for (int i = 0; i < 16; i++) begin
      w = exp_q.pop_front();
      chk("beat_window", bus.window, w);
      chk("beat_note", 32'(bus.current_note), 32'(w[1:0]));
      chk("beat_position", 32'(bus.position), 32'(i));
      for (int c = 0; c < int'(B); c++) begin
        bus.hit = (last_only[i] && c != int'(B) - 1) ? 2'b00 : plan[i];
        if (i == ign_beat && c == 1) begin
          bus.load = 1'b1;
          bus.song_in = 32'hFFFF_FFFF;
          bus.start = 1'b1;
        end
        if (i == 15 && c == int'(B) - 1) chk("done_early", 32'(bus.done), 32'd0);
        tick();
        bus.load = 1'b0;
        bus.start = 1'b0;
      end
    end
    bus.hit = 2'b00;
    chk("end_done", 32'(bus.done), 32'd1);
    chk("end_playing", 32'(bus.playing), 32'd0);
    chk("end_position", 32'(bus.position), 32'd15);
    chk("end_note", 32'(bus.current_note), 32'd0);
    chk("end_score", 32'(bus.score), exp_q.pop_front());
    chk("end_misses", 32'(bus.misses), exp_q.pop_front());
  endtask

  initial begin
    bus.load = 1'b0;
    bus.song_in = '0;
    bus.start = 1'b0;
    bus.hit = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

`ifndef SONG_PLAYER_LOOP_EN
    // Perfect presses on the E4 song.
    clear_plan();
    plan[1] = 2'b01;
    plan[2] = 2'b10;
    plan[3] = 2'b11;
    play(32'h0000_00E4, 1'b1, 1'b1);

    // Wrong, missing and extra presses, plus ignored load/start mid-play.
    clear_plan();
    plan[1] = 2'b11;
    plan[3] = 2'b11;
    plan[5] = 2'b01;
    ign_beat = 4;
    play(32'h0000_00E4, 1'b0, 1'b0);

    // Press only on the boundary cycle of note 2.
    clear_plan();
    plan[1] = 2'b01;
    plan[2] = 2'b10;
    last_only[2] = 1'b1;
    plan[3] = 2'b11;
    play(32'h0000_00E4, 1'b0, 1'b0);

    // Simultaneous load and start from DONE.
    clear_plan();
    for (int i = 0; i < 8; i++) plan[i] = 2'(3 - (i % 4));
    play(32'h1B1B_1B1B, 1'b1, 1'b0);

    // Reset mid-play, then start replays a cleared song.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midplay_reset");
    exp_song = '0;
    clear_plan();
    play(32'h0, 1'b0, 1'b0);
`else
    bus.load = 1'b1;
    bus.song_in = 32'h5555_5555;
    bus.start = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.hit = 2'b01;
    repeat (15 * B) tick();
    chk("loop_pos15", 32'(bus.position), 32'd15);
    repeat (B) tick();
    chk("loop_wrap_pos", 32'(bus.position), 32'd0);
    chk("loop_wrap_window", bus.window, 32'h5555_5555);
    chk("loop_done", 32'(bus.done), 32'd0);
    chk("loop_playing", 32'(bus.playing), 32'd1);
    chk("loop_score16", 32'(bus.score), 32'd16);
    repeat (17 * B) tick();
    chk("loop_score_sat", 32'(bus.score), 32'd31);
    chk("loop_misses", 32'(bus.misses), 32'd0);
    chk("loop_done2", 32'(bus.done), 32'd0);
    bus.hit = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
